// File: rtl/jesd_8b10b_enc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jesd_8b10b_enc_ctrl_pkg
//  Brief    : Shared constants, symbol record and popcount helper for the
//             8b/10b encode ROM sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package jesd_8b10b_enc_ctrl_pkg;

    // Control character bytes (HGFEDCBA) used with s_k = 1
    localparam logic [7:0] c_k28_0 = 8'h1C;
    localparam logic [7:0] c_k28_1 = 8'h3C;
    localparam logic [7:0] c_k28_2 = 8'h5C;
    localparam logic [7:0] c_k28_3 = 8'h7C;
    localparam logic [7:0] c_k28_4 = 8'h9C;
    localparam logic [7:0] c_k28_5 = 8'hBC;
    localparam logic [7:0] c_k28_6 = 8'hDC;
    localparam logic [7:0] c_k28_7 = 8'hFC;
    localparam logic [7:0] c_k23_7 = 8'hF7;
    localparam logic [7:0] c_k27_7 = 8'hFB;
    localparam logic [7:0] c_k29_7 = 8'hFD;
    localparam logic [7:0] c_k30_7 = 8'hFE;

    localparam logic c_rd_minus = 1'b0;
    localparam logic c_rd_plus  = 1'b1;

    localparam logic [9:0] c_k28_5_rdm = 10'b0011111010;
    localparam logic [9:0] c_k28_5_rdp = 10'b1100000101;

    typedef struct packed {
        logic [9:0] data;
        logic       k_err;
        logic       disp_err;
    } sym_t;

    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jesd_8b10b_enc_ctrl_disp_classify.sv
`default_nettype none
// ============================================================================
//  Module   : jesd_8b10b_enc_ctrl_disp_classify
//  Brief    : Classifies a 10-bit codeword by its ones count (5 / 6 / 4).
//  Revision : 1.0 - initial release
// ============================================================================
module jesd_8b10b_enc_ctrl_disp_classify
    import jesd_8b10b_enc_ctrl_pkg::*;
(
    input  logic [9:0] data,
    output logic       neutral,
    output logic       plus2,
    output logic       minus2
);

    logic [3:0] w_ones;

    assign w_ones  = popcount10(data);
    assign neutral = (w_ones == 4'd5);
    assign plus2   = (w_ones == 4'd6);
    assign minus2  = (w_ones == 4'd4);

endmodule
`default_nettype wire

// File: rtl/jesd_8b10b_enc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : jesd_8b10b_enc_ctrl
//  Brief    : Drives the RD-/RD+ encode ROM pair, picks the codeword matching
//             the running disparity and buffers symbols for the serializer.
//  Revision : 1.0 - initial release
// ============================================================================
module jesd_8b10b_enc_ctrl
    import jesd_8b10b_enc_ctrl_pkg::*;
#(
    parameter int   OBUF_DEPTH = 2,
    parameter logic RD_RESET   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_k,
    output logic [7:0] rom_addr,
    output logic       rom_rd_en,
    output logic       rom_k,
    input  logic [9:0] rdm_data,
    input  logic       rdm_k_err,
    input  logic [9:0] rdp_data,
    input  logic       rdp_k_err,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [9:0] m_data,
    output logic       m_k_err,
    output logic       m_disp_err,
    input  logic       rd_load,
    input  logic       rd_load_val,
    output logic       rd_state,
    output logic       idle
);

    logic       r_rd;
    logic       r_inflight;
    logic [1:0] r_cnt;
    sym_t       r_e0;
    sym_t       r_e1;

    logic       w_accept;
    logic       w_push;
    logic       w_pop;
    logic [2:0] w_occ;
    logic [9:0] w_sel_data;
    logic       w_sel_kerr;
    logic       w_neutral;
    logic       w_plus2;
    logic       w_minus2;
    logic       w_flip;
    sym_t       w_new;

    assign rom_addr  = s_data;
    assign rom_k     = s_k;
    assign rom_rd_en = w_accept;

    assign m_valid    = (r_cnt != 2'd0);
    assign m_data     = r_e0.data;
    assign m_k_err    = r_e0.k_err;
    assign m_disp_err = r_e0.disp_err;
    assign rd_state   = r_rd;
    assign idle       = !r_inflight && (r_cnt == 2'd0);

    assign w_pop  = m_valid && m_ready;
    assign w_push = r_inflight;

    // A head leaving this cycle frees its slot, giving one symbol per cycle
    assign w_occ    = 3'(r_inflight) + 3'(r_cnt) - 3'(w_pop);
    assign s_ready  = (w_occ < 3'(OBUF_DEPTH));
    assign w_accept = s_valid && s_ready;

    assign w_sel_data = r_rd ? rdp_data  : rdm_data;
    assign w_sel_kerr = r_rd ? rdp_k_err : rdm_k_err;

    jesd_8b10b_enc_ctrl_disp_classify u_classify (
        .data    (w_sel_data),
        .neutral (w_neutral),
        .plus2   (w_plus2),
        .minus2  (w_minus2)
    );

    always_comb begin
        w_new.data     = w_sel_data;
        w_new.k_err    = 1'b0;
        w_new.disp_err = 1'b0;
        w_flip         = 1'b0;
        if (w_sel_kerr) begin
            w_new.data  = 10'd0;
            w_new.k_err = 1'b1;
        end else if (w_neutral) begin
            w_flip = 1'b0;
        end else if (w_plus2 && (r_rd == c_rd_minus)) begin
            w_flip = 1'b1;
        end else if (w_minus2 && (r_rd == c_rd_plus)) begin
            w_flip = 1'b1;
        end else begin
            w_new.disp_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd       <= RD_RESET;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            if (w_push && w_flip) begin
                r_rd <= ~r_rd;
            end else if (rd_load && idle && !w_accept) begin
                r_rd <= rd_load_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 2'd0;
            r_e0  <= '0;
            r_e1  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_e0 <= w_new;
                    end else begin
                        r_e1 <= w_new;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_e0  <= r_e1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_e0 <= w_new;
                    end else begin
                        r_e0 <= r_e1;
                        r_e1 <= w_new;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && !w_pop && (r_cnt == 2'd2)));
        end
    end
`endif

endmodule
`default_nettype wire
